vdma_axi4s_to_axi4_core: RTL and testbench
==========================================

# vdma_axi4s_to_axi4_core

Frame-capture DMA core that writes an AXI4-Stream video input into a frame buffer in memory through an AXI4 master write port. Each frame is one tuser-marked raster of `param_width` × `param_height` pixels, one pixel per beat. Each pixel is stored as one 32-bit word at `param_addr + y*param_stride + x*4`. The core sits between a video source (camera or test pattern) and the memory interconnect. It is the write-side counterpart of the frame-buffer reader and takes the same register-level control and parameter signals.

## Interface
- AXI4_ID_WIDTH, 6: AWID width; AWID is driven as 0.
- AXI4_ADDR_WIDTH, 32: address width.
- AXI4_LEN_WIDTH, 8: AWLEN width.
- AXI4_QOS_WIDTH, 4: AWQOS width; AWQOS is driven as 0.
- AXI4S_USER_WIDTH, 1: tuser width; only bit 0 (frame start) is used.
- AXI4S_DATA_WIDTH, 24: pixel width, 1..32. The pixel is zero-extended to 32 bits for WDATA.
- INDEX_WIDTH, 8: frame counter width.
- STRIDE_WIDTH, 14 / H_WIDTH, 12 / V_WIDTH, 12: widths of the line stride (bytes), width and height parameters.
- OUTSTANDING_WIDTH, 4: width of the counter of unanswered B responses.

Ports:
- clk  in  1  clock. Everything is synchronous to it.
- reset  in  1  synchronous, active-high.
- ctl_enable  in  1  run request.
- ctl_update  in  1  when high at frame start, the parameters are latched.
- ctl_busy  out  1  high whenever the state is not IDLE.
- ctl_index  out  INDEX_WIDTH  completed-frame count.
- param_addr / param_stride / param_width / param_height / param_awlen  in  ADDR / STRIDE / H / V / LEN widths  frame parameters.
- monitor_addr / monitor_stride / monitor_width / monitor_height / monitor_awlen  out  same widths  the parameter set currently latched.
- m_axi4_aw*: awid, awaddr, awburst=INCR, awcache=4'b0011, awlen, awlock=0, awprot=0, awqos, awregion=0, awsize=3'b010, awvalid (out), awready (in).
- m_axi4_wdata  out  32
- m_axi4_wstrb  out  4  always 4'hf.
- m_axi4_wlast  out  1
- m_axi4_wvalid  out  1
- m_axi4_wready  in  1
- m_axi4_bid  in  AXI4_ID_WIDTH  ignored.
- m_axi4_bresp  in  2  ignored.
- m_axi4_bvalid  in  1
- m_axi4_bready  out  1  constant 1.
- s_axi4s_tuser  in  AXI4S_USER_WIDTH
- s_axi4s_tlast  in  1  ignored; line framing comes from the counters.
- s_axi4s_tdata  in  AXI4S_DATA_WIDTH
- s_axi4s_tvalid  in  1
- s_axi4s_tready  out  1

## Operation
- States: IDLE, SYNC, AW, W, B.
- IDLE, when ctl_enable=1:
  - The parameters are latched into the monitor registers if ctl_update=1 or this is the first frame since reset.
  - x_remain=width and y_remain=height are loaded, line_addr=addr, and the state goes to SYNC.
  - If the latched width or height is 0, the state goes straight to B instead, with no bus traffic.
- SYNC:
  - s_axi4s_tready = !tuser[0]. Beats without frame start are consumed and discarded.
  - tvalid&tuser[0] -> AW. That beat is not consumed; it becomes pixel (0,0).
- AW:
  - awvalid=1.
  - awaddr = line_addr + (width - x_remain)*4, computed at AXI4_ADDR_WIDTH.
  - awlen = min(awlen_param, x_remain-1).
  - On the awready handshake: beat counter = awlen, outstanding+1, go to W.
  - awvalid is not raised while outstanding is at its maximum value.
- W:
  - wvalid = s_axi4s_tvalid.
  - s_axi4s_tready = m_axi4_wready.
  - wdata = zero-extended tdata.
  - wlast = (beat counter == 0).
  - Each handshake decrements the beat counter and x_remain.
  - On the wlast handshake:
    - If x_remain is now nonzero -> AW.
    - Else if y_remain>1 -> reload x_remain, line_addr += stride, y_remain-1, go to AW.
    - Else -> B.
- B: wait until outstanding==0, then ctl_index+1 (wraps modulo 2^INDEX_WIDTH) and go to IDLE.
- Every bvalid decrements outstanding in any state. A bvalid in the same cycle as an AW handshake leaves outstanding unchanged.
- tuser[0] arriving mid-frame is written as ordinary data. There is no resynchronisation until the next SYNC.
- Dropping ctl_enable mid-frame does not stop the frame; the core completes it and then stays in IDLE.
- Parameter inputs changing mid-frame have no effect; only the latched copies are used.
- Reset mid-frame forces IDLE immediately. Outstanding AXI transactions are abandoned, so the interconnect must be reset together with the core.

## Timing
- Reset values:
  - awvalid=0, wvalid=0, wlast=0, s_axi4s_tready=0, ctl_busy=0, ctl_index=0.
  - All monitor outputs = 0, outstanding=0.
  - bready=1.
- All AW signals are registered. wvalid, wlast, wdata and s_axi4s_tready are combinational from state, the stream and wready, with zero added latency from stream to W.
- The IDLE->SYNC decision takes 1 cycle after ctl_enable is sampled.
- awvalid rises the cycle after the tuser beat is seen in SYNC.
- W begins the cycle after the AW handshake. The next AW follows 1 cycle after the wlast handshake.
- The index increments in the cycle B exits; ctl_busy falls the same cycle.
- The stream side is backpressured whenever the state is not W, except for the discarding done in SYNC.

## Test plan
- width=8, height=2, awlen=7, stride=64, addr=0x1000 -> AW 0x1000/len7, then 0x1040/len7; 16 W beats with wlast on beats 8 and 16; index 0->1.
- width=10, awlen=3 -> per line AW lens 3,3,1 at offsets 0x00, 0x10, 0x20.
- 5 beats without tuser, then a tuser beat with data 0xABCDEF -> the 5 beats are dropped; first wdata=0x00ABCDEF.
- Random wready, tvalid and awready stalls, plus B delayed by 20 cycles -> memory image matches the pixel sequence; index increments only after the last B.
- Change ctl_update and the parameters mid-frame -> monitor outputs change only at the next frame start. width=0 -> index increments with no AW issued.
- Reset asserted while in W -> next cycle: busy=0, wvalid=0, tready=0, index=0.

Source files
------------

// File: rtl/vdma_axi4s_to_axi4_core.sv
// Frame-capture DMA: writes one tuser-framed AXI4-Stream raster into memory
// as 32-bit words through an AXI4 write master, one line at a time.
//
// state | meaning
// IDLE  | waiting for ctl_enable; latches parameters at frame start
// SYNC  | discarding stream beats until the tuser frame-start beat
// AW    | presenting the next burst address
// W     | forwarding stream beats as write data for the current burst
// B     | frame sent; waiting for all write responses
module vdma_axi4s_to_axi4_core #(
  parameter int AXI4_ID_WIDTH     = 6,
  parameter int AXI4_ADDR_WIDTH   = 32,
  parameter int AXI4_LEN_WIDTH    = 8,
  parameter int AXI4_QOS_WIDTH    = 4,
  parameter int AXI4S_USER_WIDTH  = 1,
  parameter int AXI4S_DATA_WIDTH  = 24,
  parameter int INDEX_WIDTH       = 8,
  parameter int STRIDE_WIDTH      = 14,
  parameter int H_WIDTH           = 12,
  parameter int V_WIDTH           = 12,
  parameter int OUTSTANDING_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         ctl_enable,
  input  logic                         ctl_update,
  output logic                         ctl_busy,
  output logic [INDEX_WIDTH-1:0]       ctl_index,

  input  logic [AXI4_ADDR_WIDTH-1:0]   param_addr,
  input  logic [STRIDE_WIDTH-1:0]      param_stride,
  input  logic [H_WIDTH-1:0]           param_width,
  input  logic [V_WIDTH-1:0]           param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]    param_awlen,

  output logic [AXI4_ADDR_WIDTH-1:0]   monitor_addr,
  output logic [STRIDE_WIDTH-1:0]      monitor_stride,
  output logic [H_WIDTH-1:0]           monitor_width,
  output logic [V_WIDTH-1:0]           monitor_height,
  output logic [AXI4_LEN_WIDTH-1:0]    monitor_awlen,

  output logic [AXI4_ID_WIDTH-1:0]     m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0]   m_axi4_awaddr,
  output logic [1:0]                   m_axi4_awburst,
  output logic [3:0]                   m_axi4_awcache,
  output logic [AXI4_LEN_WIDTH-1:0]    m_axi4_awlen,
  output logic                         m_axi4_awlock,
  output logic [2:0]                   m_axi4_awprot,
  output logic [AXI4_QOS_WIDTH-1:0]    m_axi4_awqos,
  output logic [3:0]                   m_axi4_awregion,
  output logic [2:0]                   m_axi4_awsize,
  output logic                         m_axi4_awvalid,
  input  logic                         m_axi4_awready,

  output logic [31:0]                  m_axi4_wdata,
  output logic [3:0]                   m_axi4_wstrb,
  output logic                         m_axi4_wlast,
  output logic                         m_axi4_wvalid,
  input  logic                         m_axi4_wready,

  input  logic [AXI4_ID_WIDTH-1:0]     m_axi4_bid,
  input  logic [1:0]                   m_axi4_bresp,
  input  logic                         m_axi4_bvalid,
  output logic                         m_axi4_bready,

  input  logic [AXI4S_USER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                         s_axi4s_tlast,
  input  logic [AXI4S_DATA_WIDTH-1:0]  s_axi4s_tdata,
  input  logic                         s_axi4s_tvalid,
  output logic                         s_axi4s_tready
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_AW, S_W, S_B} state_t;

  localparam logic [H_WIDTH-1:0]           H_ONE   = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0]           V_ONE   = V_WIDTH'(1);
  localparam logic [AXI4_LEN_WIDTH-1:0]    L_ONE   = AXI4_LEN_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0]       IDX_ONE = INDEX_WIDTH'(1);
  localparam logic [OUTSTANDING_WIDTH-1:0] OUT_ONE = OUTSTANDING_WIDTH'(1);
  localparam logic [OUTSTANDING_WIDTH-1:0] OUT_MAX = '1;

  state_t                        state, state_nxt;
  logic                          first_frame;
  logic [H_WIDTH-1:0]            x_remain, x_nxt;
  logic [V_WIDTH-1:0]            y_remain, y_nxt;
  logic [AXI4_ADDR_WIDTH-1:0]    line_addr, line_nxt;
  logic [AXI4_LEN_WIDTH-1:0]     beat_cnt, beat_nxt;
  logic [OUTSTANDING_WIDTH-1:0]  outstanding, out_nxt;
  logic                          index_inc;

  logic                          latch;
  logic [AXI4_ADDR_WIDTH-1:0]    eff_addr;
  logic [H_WIDTH-1:0]            eff_width;
  logic [V_WIDTH-1:0]            eff_height;

  logic                          aw_hs, w_hs;
  logic                          awvalid_d;
  logic [AXI4_ADDR_WIDTH-1:0]    awaddr_d;
  logic [AXI4_LEN_WIDTH-1:0]     awlen_d;

  logic                          unused;

  assign m_axi4_awid     = '0;
  assign m_axi4_awburst  = 2'b01;
  assign m_axi4_awcache  = 4'b0011;
  assign m_axi4_awlock   = 1'b0;
  assign m_axi4_awprot   = 3'b000;
  assign m_axi4_awqos    = '0;
  assign m_axi4_awregion = 4'b0000;
  assign m_axi4_awsize   = 3'b010;
  assign m_axi4_wstrb    = 4'hf;
  assign m_axi4_bready   = 1'b1;
  assign m_axi4_wdata    = 32'(s_axi4s_tdata);

  assign unused = ^{s_axi4s_tlast, m_axi4_bid, m_axi4_bresp, s_axi4s_tuser};

  // The parameter set a new frame will run with, as seen from IDLE.
  assign latch      = first_frame | ctl_update;
  assign eff_addr   = latch ? param_addr   : monitor_addr;
  assign eff_width  = latch ? param_width  : monitor_width;
  assign eff_height = latch ? param_height : monitor_height;

  assign aw_hs = m_axi4_awvalid & m_axi4_awready;
  assign w_hs  = (state == S_W) & s_axi4s_tvalid & m_axi4_wready;

  always_comb begin
    state_nxt      = state;
    x_nxt          = x_remain;
    y_nxt          = y_remain;
    line_nxt       = line_addr;
    beat_nxt       = beat_cnt;
    index_inc      = 1'b0;
    s_axi4s_tready = 1'b0;
    m_axi4_wvalid  = 1'b0;
    m_axi4_wlast   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctl_enable) begin
          x_nxt    = eff_width;
          y_nxt    = eff_height;
          line_nxt = eff_addr;
          if (eff_width == '0 || eff_height == '0) state_nxt = S_B;
          else                                     state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        s_axi4s_tready = ~s_axi4s_tuser[0];
        if (s_axi4s_tvalid && s_axi4s_tuser[0]) state_nxt = S_AW;
      end
      S_AW: begin
        if (aw_hs) begin
          beat_nxt  = m_axi4_awlen;
          state_nxt = S_W;
        end
      end
      S_W: begin
        m_axi4_wvalid  = s_axi4s_tvalid;
        s_axi4s_tready = m_axi4_wready;
        m_axi4_wlast   = (beat_cnt == '0);
        if (w_hs) begin
          beat_nxt = beat_cnt - L_ONE;
          x_nxt    = x_remain - H_ONE;
          if (beat_cnt == '0) begin
            if (x_nxt != '0) begin
              state_nxt = S_AW;
            end else if (y_remain > V_ONE) begin
              x_nxt     = monitor_width;
              y_nxt     = y_remain - V_ONE;
              line_nxt  = line_addr + AXI4_ADDR_WIDTH'(monitor_stride);
              state_nxt = S_AW;
            end else begin
              state_nxt = S_B;
            end
          end
        end
      end
      S_B: begin
        if (outstanding == '0) begin
          index_inc = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A response arriving alongside a new burst cancels out; stray responses never underflow.
  always_comb begin
    out_nxt = outstanding;
    if (aw_hs && !m_axi4_bvalid)
      out_nxt = outstanding + OUT_ONE;
    else if (!aw_hs && m_axi4_bvalid && outstanding != '0)
      out_nxt = outstanding - OUT_ONE;
  end

  // Next burst is computed from the position the line will be at once AW is entered.
  always_comb begin
    awaddr_d  = line_nxt + (AXI4_ADDR_WIDTH'(monitor_width - x_nxt) << 2);
    awlen_d   = (32'(monitor_awlen) < (32'(x_nxt) - 32'd1)) ? monitor_awlen
                                                             : AXI4_LEN_WIDTH'(x_nxt - H_ONE);
    awvalid_d = (state_nxt == S_AW) && (out_nxt != OUT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      first_frame    <= 1'b1;
      x_remain       <= '0;
      y_remain       <= '0;
      line_addr      <= '0;
      beat_cnt       <= '0;
      outstanding    <= '0;
      ctl_busy       <= 1'b0;
      ctl_index      <= '0;
      monitor_addr   <= '0;
      monitor_stride <= '0;
      monitor_width  <= '0;
      monitor_height <= '0;
      monitor_awlen  <= '0;
      m_axi4_awvalid <= 1'b0;
      m_axi4_awaddr  <= '0;
      m_axi4_awlen   <= '0;
    end else begin
      state          <= state_nxt;
      x_remain       <= x_nxt;
      y_remain       <= y_nxt;
      line_addr      <= line_nxt;
      beat_cnt       <= beat_nxt;
      outstanding    <= out_nxt;
      ctl_busy       <= (state_nxt != S_IDLE);
      m_axi4_awvalid <= awvalid_d;
      if (state == S_IDLE && ctl_enable) begin
        first_frame <= 1'b0;
        if (latch) begin
          monitor_addr   <= param_addr;
          monitor_stride <= param_stride;
          monitor_width  <= param_width;
          monitor_height <= param_height;
          monitor_awlen  <= param_awlen;
        end
      end
      if (state_nxt == S_AW && state != S_AW) begin
        m_axi4_awaddr <= awaddr_d;
        m_axi4_awlen  <= awlen_d;
      end
      if (index_inc) ctl_index <= ctl_index + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_vdma_axi4s_to_axi4_core.sv
// Directed bench for vdma_axi4s_to_axi4_core: an AXI write slave with optional
// stalls and delayed responses records bursts into a memory image for checking.
module tb_vdma_axi4s_to_axi4_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctl_enable, ctl_update, ctl_busy;
  logic [7:0]  ctl_index;
  logic [31:0] param_addr;
  logic [13:0] param_stride;
  logic [11:0] param_width, param_height;
  logic [7:0]  param_awlen;
  logic [31:0] monitor_addr;
  logic [13:0] monitor_stride;
  logic [11:0] monitor_width, monitor_height;
  logic [7:0]  monitor_awlen;
  logic [5:0]  awid;
  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [7:0]  awlen;
  logic        awlock;
  logic [2:0]  awprot;
  logic [3:0]  awqos, awregion;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [0:0]  tuser;
  logic        tlast;
  logic [23:0] tdata;
  logic        tvalid, tready;

  int checks, failures;
  int cyc;
  logic aw_stall, w_stall, tv_stall;
  int b_delay;

  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [31:0] w_data_log[$];
  logic        w_last_log[$];
  logic [31:0] aw_pend[$];
  int          b_due[$];
  int          wbeat;
  logic [31:0] mem [logic [31:0]];

  vdma_axi4s_to_axi4_core dut (
    .clk(clk), .reset(reset),
    .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy), .ctl_index(ctl_index),
    .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
    .param_height(param_height), .param_awlen(param_awlen),
    .monitor_addr(monitor_addr), .monitor_stride(monitor_stride), .monitor_width(monitor_width),
    .monitor_height(monitor_height), .monitor_awlen(monitor_awlen),
    .m_axi4_awid(awid), .m_axi4_awaddr(awaddr), .m_axi4_awburst(awburst), .m_axi4_awcache(awcache),
    .m_axi4_awlen(awlen), .m_axi4_awlock(awlock), .m_axi4_awprot(awprot), .m_axi4_awqos(awqos),
    .m_axi4_awregion(awregion), .m_axi4_awsize(awsize), .m_axi4_awvalid(awvalid),
    .m_axi4_awready(awready),
    .m_axi4_wdata(wdata), .m_axi4_wstrb(wstrb), .m_axi4_wlast(wlast), .m_axi4_wvalid(wvalid),
    .m_axi4_wready(wready),
    .m_axi4_bid(bid), .m_axi4_bresp(bresp), .m_axi4_bvalid(bvalid), .m_axi4_bready(bready),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tdata(tdata),
    .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      awready = aw_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready  = w_stall  ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Handshakes are observed mid-cycle, so they are the ones taking effect at the next edge.
  initial begin
    wbeat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_pend.delete();
        b_due.delete();
        wbeat = 0;
      end else begin
        if (awvalid && awready) begin
          aw_addr_log.push_back(awaddr);
          aw_len_log.push_back(awlen);
          aw_pend.push_back(awaddr);
        end
        if (wvalid && wready) begin
          logic [31:0] a;
          a = (aw_pend.size() > 0) ? aw_pend[0] + 32'(wbeat * 4) : 32'hdead_0000;
          mem[a] = wdata;
          w_data_log.push_back(wdata);
          w_last_log.push_back(wlast);
          if (wlast) begin
            if (aw_pend.size() > 0) void'(aw_pend.pop_front());
            wbeat = 0;
            b_due.push_back(cyc + b_delay);
          end else begin
            wbeat++;
          end
        end
      end
    end
  end

  initial begin
    bvalid = 1'b0;
    bid    = '0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && b_due.size() > 0 && b_due[0] <= cyc) begin
        void'(b_due.pop_front());
        bvalid = 1'b1;
      end else begin
        bvalid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic u);
    logic acc;
    int gap;
    gap = tv_stall ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    acc    = 1'b0;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      if (tready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tuser  = 1'b0;
    check("beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic pulse_enable();
    @(posedge clk);
    #1;
    ctl_enable = 1'b1;
    @(posedge clk);
    #1;
    ctl_enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 3000 && ctl_busy; n++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(ctl_busy), 32'd0);
  endtask

  initial begin
    int aw0, w0;
    logic [31:0] mask;
    checks = 0; failures = 0;
    reset = 1'b1; ctl_enable = 1'b0; ctl_update = 1'b0;
    param_addr = '0; param_stride = '0; param_width = '0; param_height = '0; param_awlen = '0;
    tvalid = 1'b0; tdata = '0; tuser = '0; tlast = 1'b0;
    aw_stall = 1'b0; w_stall = 1'b0; tv_stall = 1'b0; b_delay = 2;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wlast", 32'(wlast), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_busy", 32'(ctl_busy), 32'd0);
    check("rst_index", 32'(ctl_index), 32'd0);
    check("rst_mon_addr", monitor_addr, 32'd0);
    check("rst_mon_width", 32'(monitor_width), 32'd0);
    check("rst_bready", 32'(bready), 32'd1);
    reset = 1'b0;

    // Frame 1: 8x2, one full-line burst per line
    param_addr = 32'h1000; param_stride = 14'd64; param_width = 12'd8;
    param_height = 12'd2; param_awlen = 8'd7; ctl_update = 1'b1;
    aw0 = aw_addr_log.size(); w0 = w_data_log.size();
    pulse_enable();
    check("t1_busy", 32'(ctl_busy), 32'd1);
    for (int i = 0; i < 16; i++) send_beat(24'(32'h100 + i), (i == 0));
    wait_idle("t1_done");
    check("t1_aw_count", 32'(aw_addr_log.size() - aw0), 32'd2);
    check("t1_w_count", 32'(w_data_log.size() - w0), 32'd16);
    if (aw_addr_log.size() - aw0 == 2) begin
      check("t1_aw0_addr", aw_addr_log[aw0], 32'h1000);
      check("t1_aw0_len", 32'(aw_len_log[aw0]), 32'd7);
      check("t1_aw1_addr", aw_addr_log[aw0 + 1], 32'h1040);
      check("t1_aw1_len", 32'(aw_len_log[aw0 + 1]), 32'd7);
    end
    if (w_data_log.size() - w0 == 16) begin
      mask = '0;
      for (int i = 0; i < 16; i++) mask[i] = w_last_log[w0 + i];
      check("t1_wlast_mask", mask, 32'h8080);
    end
    check("t1_mem_1000", mem[32'h1000], 32'h100);
    check("t1_mem_101c", mem[32'h101c], 32'h107);
    check("t1_mem_1040", mem[32'h1040], 32'h108);
    check("t1_mem_105c", mem[32'h105c], 32'h10f);
    check("t1_index", 32'(ctl_index), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_stays_idle", 32'(ctl_busy), 32'd0);

    // Frame 2: 10x1 with awlen 3, preceded by five beats to be discarded
    param_addr = 32'h2000; param_stride = 14'h100; param_width = 12'd10;
    param_height = 12'd1; param_awlen = 8'd3;
    aw0 = aw_addr_log.size(); w0 = w_data_log.size();
    pulse_enable();
    for (int i = 0; i < 5; i++) send_beat(24'(32'h111 + i), 1'b0);
    for (int i = 0; i < 10; i++) send_beat(24'(32'habcdef + i), (i == 0));
    wait_idle("t2_done");
    check("t2_aw_count", 32'(aw_addr_log.size() - aw0), 32'd3);
    check("t2_w_count", 32'(w_data_log.size() - w0), 32'd10);
    if (aw_addr_log.size() - aw0 == 3) begin
      check("t2_aw0_addr", aw_addr_log[aw0], 32'h2000);
      check("t2_aw0_len", 32'(aw_len_log[aw0]), 32'd3);
      check("t2_aw1_addr", aw_addr_log[aw0 + 1], 32'h2010);
      check("t2_aw1_len", 32'(aw_len_log[aw0 + 1]), 32'd3);
      check("t2_aw2_addr", aw_addr_log[aw0 + 2], 32'h2020);
      check("t2_aw2_len", 32'(aw_len_log[aw0 + 2]), 32'd1);
    end
    if (w_data_log.size() - w0 == 10) begin
      check("t2_first_wdata", w_data_log[w0], 32'h00abcdef);
      mask = '0;
      for (int i = 0; i < 10; i++) mask[i] = w_last_log[w0 + i];
      check("t2_wlast_mask", mask, 32'h288);
    end
    check("t2_mem_2024", mem[32'h2024], 32'h00abcdf8);
    check("t2_index", 32'(ctl_index), 32'd2);

    // Frame 3: 6x3 under random stalls, responses delayed 20 cycles
    aw_stall = 1'b1; w_stall = 1'b1; tv_stall = 1'b1; b_delay = 20;
    param_addr = 32'h3000; param_stride = 14'd32; param_width = 12'd6;
    param_height = 12'd3; param_awlen = 8'd3;
    aw0 = aw_addr_log.size(); w0 = w_data_log.size();
    pulse_enable();
    for (int i = 0; i < 18; i++) send_beat(24'(32'h500 + i), (i == 0));
    repeat (5) @(posedge clk);
    #1;
    check("t3_busy_before_b", 32'(ctl_busy), 32'd1);
    check("t3_index_before_b", 32'(ctl_index), 32'd2);
    wait_idle("t3_done");
    check("t3_index", 32'(ctl_index), 32'd3);
    check("t3_b_pending", 32'(b_due.size()), 32'd0);
    check("t3_aw_count", 32'(aw_addr_log.size() - aw0), 32'd6);
    if (aw_addr_log.size() - aw0 == 6) begin
      check("t3_aw1_addr", aw_addr_log[aw0 + 1], 32'h3010);
      check("t3_aw1_len", 32'(aw_len_log[aw0 + 1]), 32'd1);
      check("t3_aw5_addr", aw_addr_log[aw0 + 5], 32'h3050);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 6; x++)
        check("t3_mem", mem[32'h3000 + 32'(y * 32 + x * 4)], 32'(32'h500 + y * 6 + x));
    aw_stall = 1'b0; w_stall = 1'b0; tv_stall = 1'b0; b_delay = 2;

    // Frame 4: parameters change while the frame is running
    param_addr = 32'h4000; param_stride = 14'd64; param_width = 12'd4;
    param_height = 12'd1; param_awlen = 8'd15;
    aw0 = aw_addr_log.size();
    pulse_enable();
    param_addr = 32'h5000; param_width = 12'd2; param_height = 12'd2; param_awlen = 8'd0;
    @(posedge clk);
    #1;
    check("t4_mon_width_mid", 32'(monitor_width), 32'd4);
    check("t4_mon_addr_mid", monitor_addr, 32'h4000);
    check("t4_mon_awlen_mid", 32'(monitor_awlen), 32'd15);
    for (int i = 0; i < 4; i++) send_beat(24'(32'h700 + i), (i == 0));
    wait_idle("t4_done");
    check("t4_aw_count", 32'(aw_addr_log.size() - aw0), 32'd1);
    if (aw_addr_log.size() - aw0 == 1) begin
      check("t4_aw_addr", aw_addr_log[aw0], 32'h4000);
      check("t4_aw_len", 32'(aw_len_log[aw0]), 32'd3);
    end
    check("t4_mem_400c", mem[32'h400c], 32'h703);
    check("t4_index", 32'(ctl_index), 32'd4);
    check("t4_mon_width_after", 32'(monitor_width), 32'd4);

    // Frame 5: zero width, no bus traffic
    param_width = 12'd0;
    aw0 = aw_addr_log.size();
    pulse_enable();
    wait_idle("t5_done");
    check("t5_index", 32'(ctl_index), 32'd5);
    check("t5_aw_count", 32'(aw_addr_log.size() - aw0), 32'd0);
    check("t5_mon_width", 32'(monitor_width), 32'd0);
    check("t5_mon_addr", monitor_addr, 32'h5000);

    // Frame 6: reset while data is flowing
    param_addr = 32'h6000; param_width = 12'd8; param_height = 12'd1; param_awlen = 8'd7;
    pulse_enable();
    send_beat(24'h000800, 1'b1);
    send_beat(24'h000801, 1'b0);
    tvalid = 1'b1; tdata = 24'h000802; tuser = 1'b0;
    @(negedge clk);
    check("t6_wvalid_in_w", 32'(wvalid), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", 32'(ctl_busy), 32'd0);
    check("t6_rst_wvalid", 32'(wvalid), 32'd0);
    check("t6_rst_tready", 32'(tready), 32'd0);
    check("t6_rst_index", 32'(ctl_index), 32'd0);
    check("t6_rst_awvalid", 32'(awvalid), 32'd0);
    check("t6_rst_mon_width", 32'(monitor_width), 32'd0);
    tvalid = 1'b0;
    reset  = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
